// File: rtl/mux2in1_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | Module   : mux2in1_arbiter_if                                            |
// | Purpose  : Bundles the two requester handshakes, the mux select and the  |
// |            registered output stage of mux2in1_arbiter.                   |
// | Ports    : i_req0/i_dat0, i_req1/i_dat1 - requester beats                |
// |            o_ack0/o_ack1               - per-requester beat accept       |
// |            o_control                   - mux select (0 = dat0)           |
// |            o_valid/o_dat/i_ready       - output stage handshake          |
// | Modports : master - requesters + downstream side (drives i_*)           |
// |            slave  - arbiter side (drives o_*)                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

`ifndef MUX2IN1_WIDTH
`define MUX2IN1_WIDTH 8
`endif

interface mux2in1_arbiter_if #(
  parameter int WIDTH = `MUX2IN1_WIDTH
);
  logic             i_req0;
  logic [WIDTH-1:0] i_dat0;
  logic             i_req1;
  logic [WIDTH-1:0] i_dat1;
  logic             o_ack0;
  logic             o_ack1;
  logic             o_control;
  logic             o_valid;
  logic [WIDTH-1:0] o_dat;
  logic             i_ready;

  modport master (
    output i_req0, i_dat0, i_req1, i_dat1, i_ready,
    input  o_ack0, o_ack1, o_control, o_valid, o_dat
  );

  modport slave (
    input  i_req0, i_dat0, i_req1, i_dat1, i_ready,
    output o_ack0, o_ack1, o_control, o_valid, o_dat
  );
endinterface

`default_nettype wire

// File: rtl/mux2in1_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module   : mux2in1_arbiter                                               |
// | Purpose  : Round-robin arbiter/sequencer for a 2-to-1 data mux. Grants   |
// |            one requester at a time for at most MAX_BURST beats, drives   |
// |            the mux select and registers the selected beat into a single  |
// |            valid/ready output stage.                                     |
// | Ports    : i_clk   - rising-edge clock                                   |
// |            i_rst_n - asynchronous active-low reset                       |
// |            bus     - mux2in1_arbiter_if.slave (requests, acks, select,   |
// |                      output stage)                                       |
// | Params   : WIDTH     - data width                                        |
// |            MAX_BURST - beats per grant before rotation (1..15)           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

`ifndef MUX2IN1_WIDTH
`define MUX2IN1_WIDTH 8
`endif

module mux2in1_arbiter #(
  parameter int WIDTH     = `MUX2IN1_WIDTH,
  parameter int MAX_BURST = 4
) (
  input  wire logic          i_clk,
  input  wire logic          i_rst_n,
  mux2in1_arbiter_if.slave   bus
);

  localparam logic [3:0] C_MAX_BURST = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_t;

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic             last_q;
  logic             control_q;
  logic             valid_q;
  logic [WIDTH-1:0] dat_q;

  logic             w_space;
  logic             w_ack0;
  logic             w_ack1;
  logic             w_granted;
  logic             w_own;       // index of the requester currently granted
  logic             w_req_own;
  logic             w_req_oth;
  logic             w_burst_end;
  state_t           w_oth_state;
  logic [WIDTH-1:0] dat_d;

  assign w_space     = ~valid_q | bus.i_ready;
  assign w_ack0      = (state_q == ST_GRANT0) & bus.i_req0 & w_space;
  assign w_ack1      = (state_q == ST_GRANT1) & bus.i_req1 & w_space;

  assign w_granted   = (state_q == ST_GRANT0) | (state_q == ST_GRANT1);
  assign w_own       = (state_q == ST_GRANT1);
  assign w_req_own   = w_own ? bus.i_req1 : bus.i_req0;
  assign w_req_oth   = w_own ? bus.i_req0 : bus.i_req1;
  assign w_oth_state = w_own ? ST_GRANT0 : ST_GRANT1;
  assign w_burst_end = (cnt_q + 4'd1) == C_MAX_BURST;

  // control_q always matches the granted requester, so it is the mux select.
  assign dat_d = control_q ? bus.i_dat1 : bus.i_dat0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      last_q    <= 1'b1;
      control_q <= 1'b0;
      valid_q   <= 1'b0;
      dat_q     <= '0;
    end else begin
      // Output stage: a capture wins over a drain, so a simultaneous
      // drain+capture keeps valid high with the new beat.
      if (w_ack0 | w_ack1) begin
        dat_q   <= dat_d;
        valid_q <= 1'b1;
      end else if (valid_q & bus.i_ready) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          // On a tie, the requester not served last wins.
          if (bus.i_req0 & (~bus.i_req1 | last_q)) begin
            state_q   <= ST_GRANT0;
            control_q <= 1'b0;
            cnt_q     <= 4'd0;
          end else if (bus.i_req1) begin
            state_q   <= ST_GRANT1;
            control_q <= 1'b1;
            cnt_q     <= 4'd0;
          end
        end

        ST_GRANT0, ST_GRANT1: begin
          // Without space the grant is frozen regardless of the requests.
          if (w_space & w_granted) begin
            if (~w_req_own) begin
              // Withdraw: the cycle spent here is the one bubble on rotation.
              last_q <= w_own;
              if (w_req_oth) begin
                state_q   <= w_oth_state;
                control_q <= ~w_own;
                cnt_q     <= 4'd0;
              end else begin
                state_q <= ST_IDLE;
              end
            end else if (w_burst_end) begin
              // Beat accepted this cycle and the burst is used up.
              last_q <= w_own;
              cnt_q  <= 4'd0;
              if (w_req_oth) begin
                state_q   <= w_oth_state;
                control_q <= ~w_own;
              end
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_ack0    = w_ack0;
  assign bus.o_ack1    = w_ack1;
  assign bus.o_control = control_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_dat     = dat_q;

endmodule

`default_nettype wire
